// File: rtl/time_pkg.sv
// Shared field widths, limits and 12/24-hour conversion helpers for the time keeper.
package time_pkg;

  localparam int unsigned HW = 5;
  localparam int unsigned MW = 6;
  localparam int unsigned SW = 6;

  localparam logic [SW-1:0] MAX_SEC = 6'd59;
  localparam logic [MW-1:0] MAX_MIN = 6'd59;
  localparam logic [HW-1:0] MAX_H24 = 5'd23;
  localparam logic [HW-1:0] H12     = 5'd12;

  typedef struct packed {
    logic [HW-1:0] h24;
    logic [MW-1:0] min;
    logic [SW-1:0] sec;
  } time_t;

  // Midnight and noon both display as 12 on a 12-hour clock.
  function automatic logic [HW-1:0] h24_to_h12(input logic [HW-1:0] h24);
    logic [HW-1:0] r;
    r = (h24 >= H12) ? h24 - H12 : h24;
    return (r == '0) ? H12 : r;
  endfunction

  function automatic logic [HW-1:0] h12_to_h24(input logic [HW-1:0] h12, input logic pm);
    logic [HW-1:0] base;
    base = (h12 == H12) ? '0 : h12;
    return pm ? base + H12 : base;
  endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Load/alarm request and display bundle between a controller and the time keeper.
interface time_keeper_if;
  import time_pkg::*;

  logic          mode24;
  logic          load;
  logic          load_pm;
  logic [HW-1:0] load_h;
  logic [MW-1:0] load_m;
  logic [SW-1:0] load_s;
  logic          alarm_wr;
  logic [HW-1:0] alarm_h;
  logic [MW-1:0] alarm_m;
  logic          alarm_on;
  logic [HW-1:0] hours;
  logic [MW-1:0] minutes;
  logic [SW-1:0] seconds;
  logic          is_pm;
  logic          sec_tick;
  logic          load_err;
  logic          alarm_fire;

  modport master (
    output mode24, load, load_pm, load_h, load_m, load_s,
    output alarm_wr, alarm_h, alarm_m, alarm_on,
    input  hours, minutes, seconds, is_pm, sec_tick, load_err, alarm_fire
  );

  modport slave (
    input  mode24, load, load_pm, load_h, load_m, load_s,
    input  alarm_wr, alarm_h, alarm_m, alarm_on,
    output hours, minutes, seconds, is_pm, sec_tick, load_err, alarm_fire
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles; clr restarts the count.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pc;

  assign tick = (pc == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pc <= '0;
    else if (clr)    pc <= '0;
    else if (tick)   pc <= '0;
    else             pc <= pc + 1'b1;
  end

endmodule

// File: rtl/time_keeper.sv
// Time-of-day clock with validated load, 12/24-hour display and an optional minute alarm.
module time_keeper
  import time_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned ALARM_EN = 1
) (
  input  logic          clk,
  input  logic          reset,
  time_keeper_if.slave  tk
);

  time_t cur, nxt, ld;
  logic  tick, load_ok, load_take;
  logic  sec_tick_r, load_err_r, alarm_fire_r;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (load_take),
    .tick  (tick)
  );

  always_comb begin
    ld      = '0;
    load_ok = 1'b0;
    ld.min  = tk.load_m;
    ld.sec  = tk.load_s;
    if (tk.mode24) begin
      ld.h24  = tk.load_h;
      load_ok = (tk.load_h <= MAX_H24);
    end else begin
      ld.h24  = h12_to_h24(tk.load_h, tk.load_pm);
      load_ok = (tk.load_h >= 5'd1) && (tk.load_h <= H12);
    end
    load_ok   = load_ok && (tk.load_m <= MAX_MIN) && (tk.load_s <= MAX_SEC);
    load_take = tk.load && load_ok;
  end

  // Full seconds->minutes->hours ripple resolved within one cycle.
  always_comb begin
    nxt = cur;
    if (cur.sec == MAX_SEC) begin
      nxt.sec = '0;
      if (cur.min == MAX_MIN) begin
        nxt.min = '0;
        nxt.h24 = (cur.h24 == MAX_H24) ? '0 : cur.h24 + 1'b1;
      end else begin
        nxt.min = cur.min + 1'b1;
      end
    end else begin
      nxt.sec = cur.sec + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur        <= '0;
      sec_tick_r <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      sec_tick_r <= 1'b0;
      load_err_r <= 1'b0;
      if (load_take) begin
        cur <= ld;
      end else begin
        load_err_r <= tk.load;
        if (tick) begin
          cur        <= nxt;
          sec_tick_r <= 1'b1;
        end
      end
    end
  end

  if (ALARM_EN != 0) begin : g_alarm
    logic [HW-1:0] a_h;
    logic [MW-1:0] a_m;
    logic          a_on;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_h          <= '0;
        a_m          <= '0;
        a_on         <= 1'b0;
        alarm_fire_r <= 1'b0;
      end else begin
        if (tk.alarm_wr && (tk.alarm_h <= MAX_H24) && (tk.alarm_m <= MAX_MIN)) begin
          a_h  <= tk.alarm_h;
          a_m  <= tk.alarm_m;
          a_on <= tk.alarm_on;
        end
        alarm_fire_r <= tick && !load_take && a_on &&
                        (nxt.sec == '0) && (nxt.min == a_m) && (nxt.h24 == a_h);
      end
    end
  end else begin : g_no_alarm
    assign alarm_fire_r = 1'b0;
  end

  assign tk.hours      = tk.mode24 ? cur.h24 : h24_to_h12(cur.h24);
  assign tk.minutes    = cur.min;
  assign tk.seconds    = cur.sec;
  assign tk.is_pm      = (cur.h24 >= H12);
  assign tk.sec_tick   = sec_tick_r;
  assign tk.load_err   = load_err_r;
  assign tk.alarm_fire = alarm_fire_r;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with TICK_DIV=4: reset, loads, rejects, tick priority, alarm.
module tb_time_keeper;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   cnt;

  time_keeper_if bus ();

  time_keeper #(.TICK_DIV(4), .ALARM_EN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .tk    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_load(input logic m24, input logic pm, input int h, input int m, input int s);
    bus.mode24  = m24;
    bus.load    = 1'b1;
    bus.load_pm = pm;
    bus.load_h  = 5'(h);
    bus.load_m  = 6'(m);
    bus.load_s  = 6'(s);
  endtask

  initial begin
    reset        = 1'b1;
    bus.mode24   = 1'b0;
    bus.load     = 1'b0;
    bus.load_pm  = 1'b0;
    bus.load_h   = '0;
    bus.load_m   = '0;
    bus.load_s   = '0;
    bus.alarm_wr = 1'b0;
    bus.alarm_h  = '0;
    bus.alarm_m  = '0;
    bus.alarm_on = 1'b0;

    // Reset state
    step(); step();
    chk("rst_hours12", 32'(bus.hours), 12);
    chk("rst_min", 32'(bus.minutes), 0);
    chk("rst_sec", 32'(bus.seconds), 0);
    chk("rst_pm", 32'(bus.is_pm), 0);
    chk("rst_tick", 32'(bus.sec_tick), 0);
    chk("rst_err", 32'(bus.load_err), 0);
    chk("rst_fire", 32'(bus.alarm_fire), 0);
    bus.mode24 = 1'b1; #1;
    chk("rst_hours24", 32'(bus.hours), 0);
    bus.mode24 = 1'b0;
    reset = 1'b0;

    // First tick after four released edges
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.sec_tick) cnt++;
    end
    chk("early_ticks", 32'(cnt), 0);
    step();
    chk("first_tick", 32'(bus.sec_tick), 1);
    chk("first_sec", 32'(bus.seconds), 1);
    chk("first_hours", 32'(bus.hours), 12);

    // 11:59:59 PM rolls over to 12:00:00 AM
    drive_load(1'b0, 1'b1, 11, 59, 59);
    step();
    bus.load = 1'b0;
    chk("ld1_hours", 32'(bus.hours), 11);
    chk("ld1_min", 32'(bus.minutes), 59);
    chk("ld1_sec", 32'(bus.seconds), 59);
    chk("ld1_pm", 32'(bus.is_pm), 1);
    chk("ld1_notick", 32'(bus.sec_tick), 0);
    step(); step(); step();
    chk("roll_pre", 32'(bus.sec_tick), 0);
    step();
    chk("roll_tick", 32'(bus.sec_tick), 1);
    chk("roll_hours12", 32'(bus.hours), 12);
    chk("roll_min", 32'(bus.minutes), 0);
    chk("roll_sec", 32'(bus.seconds), 0);
    chk("roll_pm", 32'(bus.is_pm), 0);
    bus.mode24 = 1'b1; #1;
    chk("roll_hours24", 32'(bus.hours), 0);
    bus.mode24 = 1'b0;

    // 12:30:00 AM is h24 = 0
    drive_load(1'b0, 1'b0, 12, 30, 0);
    step();
    bus.load = 1'b0;
    chk("ld2_hours12", 32'(bus.hours), 12);
    chk("ld2_min", 32'(bus.minutes), 30);
    chk("ld2_pm", 32'(bus.is_pm), 0);
    bus.mode24 = 1'b1; #1;
    chk("ld2_hours24", 32'(bus.hours), 0);
    chk("ld2_sec24", 32'(bus.seconds), 0);
    chk("ld2_pm24", 32'(bus.is_pm), 0);
    bus.mode24 = 1'b0;

    // Rejected loads; the second lands on a tick edge which must still advance
    drive_load(1'b0, 1'b0, 13, 0, 0);
    step();
    bus.load = 1'b0;
    chk("rej13_err", 32'(bus.load_err), 1);
    chk("rej13_hours", 32'(bus.hours), 12);
    chk("rej13_min", 32'(bus.minutes), 30);
    step();
    chk("rej13_pulse", 32'(bus.load_err), 0);
    step();
    drive_load(1'b0, 1'b0, 0, 0, 0);
    step();
    chk("rej0_err", 32'(bus.load_err), 1);
    chk("rej0_tick", 32'(bus.sec_tick), 1);
    chk("rej0_sec", 32'(bus.seconds), 1);
    chk("rej0_min", 32'(bus.minutes), 30);
    drive_load(1'b1, 1'b0, 5, 60, 0);
    step();
    bus.load = 1'b0;
    chk("rej60_err", 32'(bus.load_err), 1);
    chk("rej60_hours", 32'(bus.hours), 0);
    chk("rej60_min", 32'(bus.minutes), 30);
    chk("rej60_sec", 32'(bus.seconds), 1);

    // Valid load on a tick edge wins and restarts the prescaler
    step(); step();
    drive_load(1'b1, 1'b0, 13, 5, 10);
    step();
    bus.load = 1'b0;
    chk("prio_hours", 32'(bus.hours), 13);
    chk("prio_sec", 32'(bus.seconds), 10);
    chk("prio_notick", 32'(bus.sec_tick), 0);
    chk("prio_noerr", 32'(bus.load_err), 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.sec_tick) cnt++;
    end
    chk("prio_gap", 32'(cnt), 0);
    step();
    chk("prio_next_tick", 32'(bus.sec_tick), 1);
    chk("prio_next_sec", 32'(bus.seconds), 11);

    // Alarm 07:00 armed; a later out-of-range write must not disarm it
    bus.alarm_wr = 1'b1;
    bus.alarm_h  = 5'd7;
    bus.alarm_m  = 6'd0;
    bus.alarm_on = 1'b1;
    drive_load(1'b1, 1'b0, 6, 59, 58);
    step();
    bus.load     = 1'b0;
    bus.alarm_h  = 5'd24;
    bus.alarm_on = 1'b0;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      bus.alarm_wr = 1'b0;
      if (bus.alarm_fire) cnt++;
    end
    chk("alm_early", 32'(cnt), 0);
    step();
    chk("alm_fire", 32'(bus.alarm_fire), 1);
    chk("alm_tick", 32'(bus.sec_tick), 1);
    chk("alm_hours", 32'(bus.hours), 7);
    chk("alm_min", 32'(bus.minutes), 0);
    chk("alm_sec", 32'(bus.seconds), 0);
    step();
    chk("alm_pulse", 32'(bus.alarm_fire), 0);

    // Loading directly onto the alarm time does not fire
    drive_load(1'b1, 1'b0, 7, 0, 0);
    step();
    bus.load = 1'b0;
    cnt = (bus.alarm_fire === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.alarm_fire) cnt++;
    end
    chk("alm_load_nofire", 32'(cnt), 0);
    chk("alm_load_sec", 32'(bus.seconds), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter TICK_DIV, default 50_000_000, clk cycles per second; legal range 1..2^26.
REQ-002 Parameter ALARM_EN, default 1; 0 removes the alarm logic and ties alarm_fire to 0.
REQ-003 clk  in  1  system clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset of all state.
REQ-005 mode24  in  1  display mode: 0 = 12-hour, 1 = 24-hour; may change at any time.
REQ-006 load  in  1  single-cycle request to set time from the load_* inputs.
REQ-007 load_pm  in  1  PM flag for a 12-hour load; ignored when mode24=1.
REQ-008 load_h  in  5  load hour: 1..12 when mode24=0, 0..23 when mode24=1.
REQ-009 load_m / load_s  in  6 each  load minute and second, 0..59.
REQ-010 alarm_wr  in  1  single-cycle strobe to write alarm_h / alarm_m / alarm_on.
REQ-011 alarm_h  in  5  alarm hour, always 24-hour encoding 0..23; alarm_m  in  6  alarm minute 0..59; alarm_on  in  1  alarm armed.
REQ-012 hours  out  5  displayed hour; minutes / seconds  out  6 each; is_pm  out  1.
REQ-013 sec_tick  out  1  one-cycle pulse when seconds advance.
REQ-014 load_err  out  1  one-cycle pulse when a load is rejected.
REQ-015 alarm_fire  out  1  one-cycle pulse on an alarm match.

Function
REQ-016 Internal state is h24 (0..23), min, sec, prescaler count pc (0..TICK_DIV-1), alarm registers.
REQ-017 Each cycle without load, pc increments; at pc==TICK_DIV-1, pc wraps to 0 and a tick occurs; sec_tick is high in the cycle after the tick edge.
REQ-018 Tick: sec 59->0 carries to min; min 59->0 carries to h24; h24 23->0; all carries resolve in the same cycle.
REQ-019 Display (combinational from state and mode24): mode24=1 -> hours=h24; mode24=0 -> hours = (h24 mod 12 == 0) ? 12 : h24 mod 12; is_pm = (h24 >= 12) in both modes.
REQ-020 Load validation uses mode24 as sampled in the load cycle; an out-of-range field rejects the whole load: state unchanged, load_err pulses next cycle.
REQ-021 Valid 12-hour load: h24 = (load_h==12 ? 0 : load_h) + (load_pm ? 12 : 0). Valid 24-hour load: h24 = load_h.
REQ-022 Valid load writes h24/min/sec and clears pc to 0, visible the cycle after the load; load has priority over a coincident tick, which is discarded; no sec_tick for that cycle.
REQ-023 Rejected load leaves pc counting; a coincident tick proceeds normally.
REQ-024 alarm_wr stores the alarm fields if alarm_h<=23 and alarm_m<=59, otherwise ignored silently; it is independent of load.
REQ-025 alarm_fire pulses, aligned with sec_tick, only when a tick produces sec==0, min==alarm_m, h24==alarm_h with alarm_on stored as 1; a load onto the alarm time does not fire.
REQ-026 A mode24 change alters only display outputs, never state or timing.

Reset
REQ-027 reset asserted: h24=0, min=0, sec=0, pc=0, alarm registers 0 / alarm_on=0; sec_tick, load_err, alarm_fire = 0 immediately.
REQ-028 Displayed values after reset: 12-hour mode shows 12:00:00, is_pm=0; 24-hour mode shows 00:00:00.
REQ-029 reset mid-count or mid-load aborts that operation; the first tick after release occurs TICK_DIV cycles after the first released edge.

Structure
REQ-030 Package time_pkg holds the field widths (5/6/6), MAX_SEC=59, MAX_MIN=59, MAX_H24=23, and the 12/24 conversion functions.
REQ-031 The prescaler is sub-module tick_prescaler, parameter TICK_DIV, ports clk, reset, clr, tick.

Verification
REQ-032 TICK_DIV=4, reset, mode24=0 -> hours=12, minutes=0, seconds=0, is_pm=0; first sec_tick after 4 cycles.
REQ-033 Load 11:59:59 PM in 12-hour mode, one tick -> 12:00:00 AM, h24=0; mode24=1 then shows 00:00:00.
REQ-034 Load 12:30:00 AM in 12-hour mode -> h24=0; mode24=1 shows 00:30:00, is_pm=0.
REQ-035 12-hour load with load_h=13 or 0, or 24-hour load with load_m=60 -> load_err pulse, time unchanged.
REQ-036 Alarm 07:00 armed, load 06:59:58 -> alarm_fire exactly once, with the tick to 07:00:00; load directly to 07:00:00 -> no fire.
REQ-037 Load asserted in a tick cycle -> loaded value appears, no sec_tick, next tick TICK_DIV cycles later.
